sid_reg_writer: RTL

SID_REG_WRITER -- requirements
Module: sid_reg_writer

---
 rtl/sid_reg_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sid_reg_writer.sv
// sid_reg_writer: queues host register-write and delay commands and replays
// them into the SID core at the SID tick rate (one command per ce_1m tick).
// Optional feature: define SID_REG_WRITER_SHADOW_EN to keep a readable shadow
// copy of the 25 real SID registers; without it rd_data reads as 0x00.
module sid_reg_writer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce_1m,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_wait,
    input  logic [4:0]                    cmd_addr,
    input  logic [7:0]                    cmd_data,
    output logic                          sid_we,
    output logic [4:0]                    sid_addr,
    output logic [7:0]                    sid_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic [4:0]                    rd_addr,
    output logic [7:0]                    rd_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [4:0] LAST_REG = 5'h18;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [13:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic [7:0]         delay_cnt;
    logic [7:0]         delay_cnt_next;
    logic               push;
    logic               pop;
    logic               issue_write;
    logic               head_wait;
    logic [4:0]         head_addr;
    logic [7:0]         head_data;

    assign cmd_ready  = (count != LVL_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign {head_wait, head_addr, head_data} = fifo_mem[rd_ptr];
    assign fifo_level = count;
    assign busy       = (count != '0) || (state != IDLE);

    // Command storage; an entry is only written when the host handshake completes
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= {cmd_wait, cmd_addr, cmd_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // State register and delay counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            delay_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            delay_cnt <= delay_cnt_next;
        end
    end

    // Pop decision and delay sequencing; the FIFO count seen here is the
    // pre-edge occupancy, so a command pushed on this tick waits for the next
    always_comb begin
        state_next     = state;
        delay_cnt_next = delay_cnt;
        pop            = 1'b0;
        issue_write    = 1'b0;
        case (state)
            IDLE: begin
                if (ce_1m && (count != '0)) begin
                    pop = 1'b1;
                    if (!head_wait) begin
                        issue_write = 1'b1;
                    end else if (head_data != 8'd0) begin
                        state_next     = WAIT;
                        delay_cnt_next = head_data;
                    end
                end
            end
            WAIT: begin
                if (ce_1m) begin
                    delay_cnt_next = delay_cnt - 8'd1;
                    if (delay_cnt <= 8'd1) begin
                        delay_cnt_next = 8'd0;
                        state_next     = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // SID write port: one-clock strobe, address/data held until the next write
    always_ff @(posedge clk) begin
        if (reset) begin
            sid_we   <= 1'b0;
            sid_addr <= 5'h00;
            sid_data <= 8'h00;
        end else begin
            sid_we <= issue_write;
            if (issue_write) begin
                sid_addr <= head_addr;
                sid_data <= head_data;
            end
        end
    end

`ifdef SID_REG_WRITER_SHADOW_EN
    logic [7:0] shadow [25];

    // Shadow copy of the real SID registers, updated on the same edge as sid_we
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 25; i++) begin
                shadow[i] <= 8'h00;
            end
        end else if (issue_write && (head_addr <= LAST_REG)) begin
            shadow[head_addr] <= head_data;
        end
    end

    // Registered readback; addresses beyond the real register set read as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else if (rd_addr <= LAST_REG) begin
            rd_data <= shadow[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = 8'h00;
`endif

endmodule
